// File: rtl/cfg_ser_pkg.sv
// Shared types and defaults for the serial configuration transmitter.
// Strobe support is selected with CFG_STROBE_EN.
package cfg_ser_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLR   = 2'd1,
    SHIFT = 2'd2,
    STRB  = 2'd3
  } state_t;

  localparam int CFG_WIDTH_DEF = 33;
  localparam int CFG_CLR_DEF   = 2;

endpackage

// File: rtl/cfg_ser_shreg.sv
// Load/shift-right register; the serial output is always bit 0.
// Used by cfg_ser_tx (CFG_STROBE_EN does not affect this block).
module cfg_ser_shreg
  import cfg_ser_pkg::*;
#(
  parameter int WIDTH = CFG_WIDTH_DEF
) (
  input  logic             Clk,
  input  logic             Resetn,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic             q
);

  logic [WIDTH-1:0] r;

  always_ff @(posedge Clk) begin
    if (!Resetn) begin
      r <= '0;
    end else if (load) begin
      r <= d;
    end else if (shift) begin
      r <= r >> 1;
    end
  end

  assign q = r[0];

endmodule

// File: rtl/cfg_ser_tx.sv
// Serial configuration transmitter: clear, then LSB-first word shift.
// Define CFG_STROBE_EN to add the end-of-frame Strobe pulse.
module cfg_ser_tx
  import cfg_ser_pkg::*;
#(
  parameter int WIDTH      = CFG_WIDTH_DEF,
  parameter int CLR_CYCLES = CFG_CLR_DEF
) (
  input  logic             Clk,
  input  logic             Resetn,
  input  logic [WIDTH-1:0] Word_in,
  input  logic             Valid,
  output logic             Ready,
  output logic             Cfg_out,
  output logic             Cfg_rstn,
  output logic             Busy
`ifdef CFG_STROBE_EN
  ,
  output logic             Strobe
`endif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [3:0] LAST_CLR = 4'(CLR_CYCLES - 1);

  state_t        state;
  state_t        nextState;
  logic [CW-1:0] bitCnt;
  logic [3:0]    clrCnt;
  logic          take;
  logic          shift;
  logic          shOut;

  assign Ready = (state == IDLE);
  assign take  = Ready && Valid;
  assign shift = (nextState == SHIFT);

  cfg_ser_shreg #(
    .WIDTH(WIDTH)
  ) u_shreg (
    .Clk   (Clk),
    .Resetn(Resetn),
    .load  (take),
    .shift (shift),
    .d     (Word_in),
    .q     (shOut)
  );

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE: begin
        if (take) nextState = CLR;
      end
      CLR: begin
        if (clrCnt == LAST_CLR) nextState = SHIFT;
      end
      SHIFT: begin
        if (bitCnt == LAST_BIT) begin
`ifdef CFG_STROBE_EN
          nextState = STRB;
`else
          nextState = IDLE;
`endif
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // Outputs are registered from the next state so each one lines up
  // with the state it belongs to, with no input-to-output path.
  always_ff @(posedge Clk) begin
    if (!Resetn) begin
      state    <= IDLE;
      bitCnt   <= '0;
      clrCnt   <= '0;
      Cfg_out  <= 1'b0;
      Cfg_rstn <= 1'b1;
      Busy     <= 1'b0;
`ifdef CFG_STROBE_EN
      Strobe   <= 1'b0;
`endif
    end else begin
      state <= nextState;
      if (state == CLR && nextState == CLR) begin
        clrCnt <= clrCnt + 4'd1;
      end else begin
        clrCnt <= '0;
      end
      if (state == SHIFT && nextState == SHIFT) begin
        bitCnt <= bitCnt + CW'(1);
      end else begin
        bitCnt <= '0;
      end
      Cfg_out  <= shift && shOut;
      Cfg_rstn <= (nextState != CLR);
      Busy     <= (nextState != IDLE);
`ifdef CFG_STROBE_EN
      Strobe   <= (nextState == STRB);
`endif
    end
  end

endmodule
